// File: rtl/sdr_init_seq.sv
// SDRAM power-up initialisation sequencer: NOP wait, PRECHARGE ALL, N x AUTO REFRESH,
// LOAD MODE, then hands the bus to the scheduler. Re-init from DONE skips the power-up wait.
module sdr_init_seq #(
    parameter int unsigned SDR_ADDR_W = 13,
    parameter int unsigned SDR_BA_W   = 2,
    parameter int unsigned PWRUP_CYC  = 600
) (
    input  logic                  sdram_clk,
    input  logic                  sdram_rst,
    input  logic [3:0]            cfg_trp_d,
    input  logic [3:0]            cfg_trfc_d,
    input  logic [3:0]            cfg_tmrd_d,
    input  logic [3:0]            cfg_ref_cnt,
    input  logic [SDR_ADDR_W-1:0] cfg_mode_reg,
    input  logic                  init_req,
    output logic                  sdr_cke,
    output logic                  sdr_cs_n,
    output logic                  sdr_ras_n,
    output logic                  sdr_cas_n,
    output logic                  sdr_we_n,
    output logic [SDR_ADDR_W-1:0] sdr_addr,
    output logic [SDR_BA_W-1:0]   sdr_ba,
    output logic                  init_busy,
    output logic                  init_done
);
    localparam int unsigned PWR_W = $clog2(PWRUP_CYC + 1);

    localparam logic [3:0] CMD_NOP      = 4'b0111;
    localparam logic [3:0] CMD_PRE      = 4'b0010;
    localparam logic [3:0] CMD_REF      = 4'b0001;
    localparam logic [3:0] CMD_LMR      = 4'b0000;
    localparam logic [3:0] CMD_DESELECT = 4'b1111;

    localparam logic [SDR_ADDR_W-1:0] PRE_ALL_ADDR = SDR_ADDR_W'(32'h400);

    typedef enum logic [3:0] {
        ST_RST, ST_PWRUP, ST_PRE, ST_TRP, ST_REF, ST_TRFC, ST_LMR, ST_TMRD, ST_DONE
    } state_t;

    state_t                state, state_nx;
    logic [PWR_W-1:0]      pwr_cnt, pwr_cnt_nx;
    logic [3:0]            dly_cnt, dly_cnt_nx;
    logic [3:0]            ref_cnt, ref_cnt_nx;
    logic [3:0]            trp_q, trp_nx, trfc_q, trfc_nx, tmrd_q, tmrd_nx, refs_q, refs_nx;
    logic [SDR_ADDR_W-1:0] mode_q, mode_nx;
    logic [3:0]            ref_tgt;
    logic                  capture;

    logic                  cke_nx, busy_nx, done_nx;
    logic [3:0]            cmd_nx;
    logic [SDR_ADDR_W-1:0] addr_nx;
    logic [SDR_BA_W-1:0]   ba_nx;

    // Zero-length timing gaps are stretched to one NOP cycle.
    function automatic logic [3:0] min1(input logic [3:0] v);
        return (v == 4'd0) ? 4'd1 : v;
    endfunction

    assign ref_tgt = (refs_q < 4'd2) ? 4'd2 : refs_q;

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state     <= ST_RST;
            pwr_cnt   <= '0;
            dly_cnt   <= '0;
            ref_cnt   <= '0;
            trp_q     <= '0;
            trfc_q    <= '0;
            tmrd_q    <= '0;
            refs_q    <= '0;
            mode_q    <= '0;
            sdr_cke   <= 1'b0;
            {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_DESELECT;
            sdr_addr  <= '0;
            sdr_ba    <= '0;
            init_busy <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nx;
            pwr_cnt   <= pwr_cnt_nx;
            dly_cnt   <= dly_cnt_nx;
            ref_cnt   <= ref_cnt_nx;
            trp_q     <= trp_nx;
            trfc_q    <= trfc_nx;
            tmrd_q    <= tmrd_nx;
            refs_q    <= refs_nx;
            mode_q    <= mode_nx;
            sdr_cke   <= cke_nx;
            {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= cmd_nx;
            sdr_addr  <= addr_nx;
            sdr_ba    <= ba_nx;
            init_busy <= busy_nx;
            init_done <= done_nx;
        end
    end

    // Next state and counters; outputs are decoded from the next state so they register in step.
    always_comb begin
        state_nx   = state;
        pwr_cnt_nx = pwr_cnt;
        dly_cnt_nx = dly_cnt;
        ref_cnt_nx = ref_cnt;
        capture    = 1'b0;

        case (state)
            ST_RST: begin
                state_nx   = ST_PWRUP;
                pwr_cnt_nx = PWR_W'(PWRUP_CYC - 1);
                capture    = 1'b1;
            end
            ST_PWRUP: begin
                if (pwr_cnt == '0) state_nx = ST_PRE;
                else               pwr_cnt_nx = pwr_cnt - PWR_W'(1);
            end
            ST_PRE: begin
                state_nx   = ST_TRP;
                dly_cnt_nx = 4'(min1(trp_q) - 4'd1);
                ref_cnt_nx = 4'd0;
            end
            ST_TRP: begin
                if (dly_cnt == 4'd0) state_nx = ST_REF;
                else                 dly_cnt_nx = dly_cnt - 4'd1;
            end
            ST_REF: begin
                state_nx   = ST_TRFC;
                dly_cnt_nx = 4'(min1(trfc_q) - 4'd1);
                if (ref_cnt != 4'hf) ref_cnt_nx = ref_cnt + 4'd1;
            end
            ST_TRFC: begin
                if (dly_cnt == 4'd0) state_nx = (ref_cnt < ref_tgt) ? ST_REF : ST_LMR;
                else                 dly_cnt_nx = dly_cnt - 4'd1;
            end
            ST_LMR: begin
                state_nx   = ST_TMRD;
                dly_cnt_nx = 4'(min1(tmrd_q) - 4'd1);
            end
            ST_TMRD: begin
                if (dly_cnt == 4'd0) state_nx = ST_DONE;
                else                 dly_cnt_nx = dly_cnt - 4'd1;
            end
            ST_DONE: begin
                if (init_req) begin
                    state_nx = ST_PRE;
                    capture  = 1'b1;
                end
            end
            default: state_nx = ST_RST;
        endcase

        trp_nx  = capture ? cfg_trp_d    : trp_q;
        trfc_nx = capture ? cfg_trfc_d   : trfc_q;
        tmrd_nx = capture ? cfg_tmrd_d   : tmrd_q;
        refs_nx = capture ? cfg_ref_cnt  : refs_q;
        mode_nx = capture ? cfg_mode_reg : mode_q;

        cke_nx  = 1'b1;
        cmd_nx  = CMD_NOP;
        addr_nx = '0;
        ba_nx   = '0;
        busy_nx = 1'b1;
        done_nx = 1'b0;
        case (state_nx)
            ST_RST: begin
                cke_nx  = 1'b0;
                cmd_nx  = CMD_DESELECT;
                busy_nx = 1'b0;
            end
            ST_PRE: begin
                cmd_nx  = CMD_PRE;
                addr_nx = PRE_ALL_ADDR;
            end
            ST_REF:  cmd_nx = CMD_REF;
            ST_LMR: begin
                cmd_nx  = CMD_LMR;
                addr_nx = mode_q;
            end
            ST_DONE: begin
                busy_nx = 1'b0;
                done_nx = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sdr_init_seq.sv
// Bench for sdr_init_seq: expected command events are queued with their cycle numbers,
// a negedge monitor pops and compares them and checks pin-level invariants every cycle.
module tb_sdr_init_seq;
    localparam int unsigned AW = 13;
    localparam int unsigned BW = 2;

    typedef enum int {EV_PRE, EV_REF, EV_LMR, EV_DONE, EV_RST} ev_t;
    typedef struct {
        ev_t           kind;
        int            cyc;
        logic [AW-1:0] addr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    trp = 4'd2, trfc = 4'd7, tmrd = 4'd2, refc = 4'd2;
    logic [AW-1:0] mode = 13'h033;
    logic          init_req = 1'b0;
    logic          cke, cs_n, ras_n, cas_n, we_n, busy, done;
    logic [AW-1:0] addr;
    logic [BW-1:0] ba;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   base = 0;
    bit   mon_en = 1'b0;
    logic [3:0] prev_cmd = 4'b1111;
    logic prev_done = 1'b0;
    logic prev_cke = 1'b0;

    sdr_init_seq dut (
        .sdram_clk   (clk),
        .sdram_rst   (rst),
        .cfg_trp_d   (trp),
        .cfg_trfc_d  (trfc),
        .cfg_tmrd_d  (tmrd),
        .cfg_ref_cnt (refc),
        .cfg_mode_reg(mode),
        .init_req    (init_req),
        .sdr_cke     (cke),
        .sdr_cs_n    (cs_n),
        .sdr_ras_n   (ras_n),
        .sdr_cas_n   (cas_n),
        .sdr_we_n    (we_n),
        .sdr_addr    (addr),
        .sdr_ba      (ba),
        .init_busy   (busy),
        .init_done   (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: per-cycle pin invariants plus event matching against the queue.
    always @(negedge clk) begin : mon
        logic [3:0] cmd;
        bit         got;
        bit         ok;
        ev_t        k;
        exp_t       e;
        cmd = {cs_n, ras_n, cas_n, we_n};
        got = 1'b0;
        k   = EV_PRE;
        if (mon_en) begin
            checks++;
            if (done === 1'b1 && busy === 1'b1) begin
                failures++;
                $display("FAIL done_busy_overlap cyc=%0d done=%b busy=%b required not both 1", cyc - base, done, busy);
            end
            ok = (ba === '0);
            case (cmd)
                4'b0111: ok = ok && (cke === 1'b1) && (addr === '0);
                4'b1111: ok = ok && (cke === 1'b0) && (addr === '0) && (busy === 1'b0) && (done === 1'b0);
                4'b0010: ok = ok && (cke === 1'b1) && (addr === 13'h400);
                4'b0001: ok = ok && (cke === 1'b1) && (addr === '0);
                4'b0000: ok = ok && (cke === 1'b1);
                default: ok = 1'b0;
            endcase
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL pins cyc=%0d cmd=%b cke=%b addr=%h ba=%h busy=%b done=%b", cyc - base, cmd, cke, addr, ba, busy, done);
            end
            if (cmd === 4'b0010 || cmd === 4'b0001 || cmd === 4'b0000) begin
                checks++;
                if (cmd === prev_cmd) begin
                    failures++;
                    $display("FAIL cmd_width cyc=%0d cmd=%b repeated, required single cycle", cyc - base, cmd);
                end
            end
            if (cmd === 4'b0010)                         begin got = 1'b1; k = EV_PRE;  end
            else if (cmd === 4'b0001)                    begin got = 1'b1; k = EV_REF;  end
            else if (cmd === 4'b0000)                    begin got = 1'b1; k = EV_LMR;  end
            else if (done === 1'b1 && prev_done !== 1'b1) begin got = 1'b1; k = EV_DONE; end
            else if (cke === 1'b0 && prev_cke === 1'b1)   begin got = 1'b1; k = EV_RST;  end
            if (got) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event kind=%0d at cyc=%0d, required none", int'(k), cyc - base);
                end else begin
                    e = q.pop_front();
                    if (k != e.kind || cyc != e.cyc || (k == EV_LMR && addr !== e.addr)) begin
                        failures++;
                        $display("FAIL event got kind=%0d abs_cyc=%0d addr=%h, required kind=%0d abs_cyc=%0d addr=%h",
                                 int'(k), cyc, addr, int'(e.kind), e.cyc, e.addr);
                    end
                end
            end
        end
        prev_cmd  = cmd;
        prev_done = done;
        prev_cke  = cke;
    end

    task automatic push_abs(input ev_t k, input int c, input logic [AW-1:0] a);
        exp_t e;
        e.kind = k;
        e.cyc  = c;
        e.addr = a;
        q.push_back(e);
    endtask

    task automatic push_rel(input ev_t k, input int r, input logic [AW-1:0] a);
        push_abs(k, base + r, a);
    endtask

    // p = PRECHARGE cycle; gap arguments are the effective (hand-resolved) NOP counts.
    task automatic push_seq(input int p, input int g_rp, input int g_rfc, input int nref,
                            input int g_mrd, input logic [AW-1:0] m);
        int r;
        push_rel(EV_PRE, p, 13'h400);
        r = p + 1 + g_rp;
        for (int i = 0; i < nref; i++) begin
            push_rel(EV_REF, r, '0);
            r = r + g_rfc + 1;
        end
        push_rel(EV_LMR, r, m);
        push_rel(EV_DONE, r + 1 + g_mrd, '0);
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1;
        push_abs(EV_RST, cyc + 1, '0);
        repeat (hold) @(negedge clk);
    endtask

    task automatic release_rst(input logic [3:0] a_rp, input logic [3:0] a_rfc, input logic [3:0] a_ref,
                               input logic [3:0] a_mrd, input logic [AW-1:0] m);
        trp  = a_rp;
        trfc = a_rfc;
        refc = a_ref;
        tmrd = a_mrd;
        mode = m;
        rst  = 1'b0;
        base = cyc + 1;
    endtask

    task automatic wait_rel(input int r);
        while (cyc < base + r) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d next_abs_cyc=%0d, required 0 pending", q.size(), q[0].cyc);
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, want);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cke", 32'(cke), 32'd0);
        chk("rst_cmd", 32'({cs_n, ras_n, cas_n, we_n}), 32'hf);
        chk("rst_addr_ba", 32'({addr, ba}), 32'd0);
        chk("rst_busy_done", 32'({busy, done}), 32'd0);
        prev_cke = cke;
        mon_en = 1'b1;

        // Nominal sequence with literal cycle numbers.
        release_rst(4'd2, 4'd7, 4'd2, 4'd2, 13'h033);
        @(negedge clk);
        chk("cyc0_cke_busy", 32'({cke, busy, done}), 32'b110);
        chk("cyc0_cmd_nop", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
        push_rel(EV_PRE, 600, 13'h400);
        push_rel(EV_REF, 603, '0);
        push_rel(EV_REF, 611, '0);
        push_rel(EV_LMR, 619, 13'h033);
        push_rel(EV_DONE, 622, '0);
        drain(800);

        // All delays 0 and ref count 0: single-NOP gaps, two refreshes.
        do_reset(3);
        release_rst(4'd0, 4'd0, 4'd0, 4'd0, 13'h021);
        push_seq(600, 1, 1, 2, 1, 13'h021);
        drain(800);

        // Five refreshes, 8 cycles apart.
        do_reset(3);
        release_rst(4'd2, 4'd7, 4'd5, 4'd2, 13'h033);
        push_seq(600, 2, 7, 5, 2, 13'h033);
        drain(800);

        // Reset during the second tRFC window, held 3 cycles, full restart.
        do_reset(3);
        release_rst(4'd2, 4'd7, 4'd2, 4'd2, 13'h033);
        push_rel(EV_PRE, 600, 13'h400);
        push_rel(EV_REF, 603, '0);
        push_rel(EV_REF, 611, '0);
        wait_rel(614);
        do_reset(3);
        release_rst(4'd2, 4'd7, 4'd2, 4'd2, 13'h033);
        push_seq(600, 2, 7, 2, 2, 13'h033);
        drain(800);

        // init_req in TRP is ignored; in DONE it re-runs from PRE with freshly captured tRP.
        do_reset(3);
        release_rst(4'd2, 4'd7, 4'd2, 4'd2, 13'h033);
        push_seq(600, 2, 7, 2, 2, 13'h033);
        wait_rel(601);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        drain(800);
        wait_rel(630);
        trp = 4'd1;
        init_req = 1'b1;
        push_seq(631, 1, 7, 2, 2, 13'h033);
        @(negedge clk);
        init_req = 1'b0;
        chk("reinit_done_busy_cke", 32'({done, busy, cke}), 32'b011);
        drain(200);

        // Mid-sequence config changes must not affect the running sequence.
        do_reset(3);
        release_rst(4'd2, 4'd7, 4'd2, 4'd2, 13'h033);
        push_seq(600, 2, 7, 2, 2, 13'h033);
        wait_rel(605);
        mode = 13'h155;
        trfc = 4'd3;
        drain(800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
